pixel_coord_tagger: RTL and testbench

Streaming front end for the rotation stage. It accepts a raster-order pixel stream over a valid/ready handshake and emits each pixel tagged with row, column, centre-relative signed coordinates (half-pixel units) and frame markers. The rotation datapath consumes these tags directly, with no coordinate arithmetic of its own. Frames are armed by `start`, counted to ROWS×COLS, drained, and closed with a `frame_done` pulse.

---
 rtl/improve_pkg.sv | 48 ++++
 rtl/pixel_coord_tagger_skid_buffer.sv | 69 ++++++
 rtl/pixel_coord_tagger.sv | 121 ++++++++++++
 tb/tb_pixel_coord_tagger.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/improve_pkg.sv
// ============================================================================
// Module   : improve_pkg
// Purpose  : Shared types and width helpers for the pixel tagger and rotation stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package improve_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } tag_state_t;

   localparam int BEAT_PIX_W   = 8;
   localparam int BEAT_IDX_W   = 8;
   localparam int BEAT_COORD_W = 11;

   typedef struct packed {
      logic [BEAT_PIX_W-1:0]          data;
      logic [BEAT_IDX_W-1:0]          row;
      logic [BEAT_IDX_W-1:0]          col;
      logic signed [BEAT_COORD_W-1:0] xs;
      logic signed [BEAT_COORD_W-1:0] ys;
      logic                           sof;
      logic                           eof;
   } pix_beat_t;

   // Index width that never collapses to zero for a 1-pixel dimension.
   function automatic int idx_w(input int n);
      if (n > 1) return $clog2(n);
      else       return 1;
   endfunction

   // Smallest signed width w with 2^(w-1) > max(rows, cols).
   function automatic int coord_w(input int rows, input int cols);
      int m;
      int w;
      m = (rows > cols) ? rows : cols;
      w = 1;
      while ((1 << (w - 1)) <= m) w = w + 1;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_coord_tagger_skid_buffer.sv
// ============================================================================
// Module   : skid_buffer
// Purpose  : Output register plus one skid register with a registered ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module skid_buffer #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_enable,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_ready,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          r_ready;
   logic          r_out_valid;
   logic          r_skid_full;
   logic [DW-1:0] r_out_data;
   logic [DW-1:0] r_skid_data;
   logic          w_acc;
   logic          w_cons;
   logic          w_skid_full_nxt;

   assign w_acc  = i_valid & r_ready;
   assign w_cons = r_out_valid & i_ready;
   // Skid fills only when an accept lands on a stalled output register.
   assign w_skid_full_nxt = r_skid_full ? !w_cons : (w_acc & r_out_valid & !i_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready     <= 1'b0;
         r_out_valid <= 1'b0;
         r_skid_full <= 1'b0;
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else begin
         r_ready     <= i_enable & !w_skid_full_nxt;
         r_skid_full <= w_skid_full_nxt;
         if (!r_out_valid || w_cons) begin
            if (r_skid_full) begin
               r_out_data  <= r_skid_data;
               r_out_valid <= 1'b1;
            end else if (w_acc) begin
               r_out_data  <= i_data;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
         if (w_acc && r_out_valid && !i_ready) begin
            r_skid_data <= i_data;
         end
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/pixel_coord_tagger.sv
// ============================================================================
// Module   : pixel_coord_tagger
// Purpose  : Tags a raster pixel stream with row/col, centred coordinates and frame markers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_coord_tagger
   import improve_pkg::*;
#(
   parameter int ROWS    = 242,
   parameter int COLS    = 247,
   parameter int PIX_W   = 8,
   parameter int COORD_W = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [PIX_W-1:0]          s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [PIX_W-1:0]          m_data,
   output logic [idx_w(ROWS)-1:0]    m_row,
   output logic [idx_w(COLS)-1:0]    m_col,
   output logic signed [COORD_W-1:0] m_xs,
   output logic signed [COORD_W-1:0] m_ys,
   output logic                      m_sof,
   output logic                      m_eof,
   output logic                      frame_done,
   output logic                      busy
);

   localparam int c_RW = idx_w(ROWS);
   localparam int c_CW = idx_w(COLS);
   localparam int c_DW = PIX_W + c_RW + c_CW + 2 * COORD_W + 2;
   localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(ROWS - 1);
   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);

   tag_state_t          r_state;
   tag_state_t          w_state_nxt;
   logic [c_RW-1:0]     r_row;
   logic [c_CW-1:0]     r_col;
   logic                w_acc;
   logic                w_sof;
   logic                w_eof;
   logic                w_eof_cons;
   logic [COORD_W-1:0]  w_xs;
   logic [COORD_W-1:0]  w_ys;
   logic [c_DW-1:0]     w_beat_in;
   logic [c_DW-1:0]     w_beat_out;

   assign w_acc      = s_valid & s_ready;
   assign w_sof      = (r_row == '0) && (r_col == '0);
   assign w_eof      = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
   assign w_eof_cons = m_valid & m_ready & m_eof;

   // Half-pixel units: doubling the index keeps odd dimensions exact.
   assign w_xs = COORD_W'({r_col, 1'b0}) - COORD_W'(COLS - 1);
   assign w_ys = COORD_W'({r_row, 1'b0}) - COORD_W'(ROWS - 1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start)          w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_acc && w_eof) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (w_eof_cons)     w_state_nxt = ST_IDLE;
         default:                       w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_row <= '0;
         r_col <= '0;
      end else if (w_acc) begin
         if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign w_beat_in = {s_data, r_row, r_col, w_xs, w_ys, w_sof, w_eof};

   skid_buffer #(
      .DW (c_DW)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_enable (w_state_nxt == ST_ACTIVE),
      .i_valid  (s_valid),
      .i_data   (w_beat_in),
      .o_ready  (s_ready),
      .o_valid  (m_valid),
      .i_ready  (m_ready),
      .o_data   (w_beat_out)
   );

   assign {m_data, m_row, m_col, m_xs, m_ys, m_sof, m_eof} = w_beat_out;

   assign frame_done = (r_state == ST_DRAIN) & w_eof_cons;
   assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pixel_coord_tagger.sv
// ============================================================================
// Module   : tb_pixel_coord_tagger
// Purpose  : Directed self-checking bench: 3x4 frames under several m_ready patterns, plus 1x1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pixel_coord_tagger;
   import improve_pkg::*;

   localparam int B_CW = coord_w(1, 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic               a_start, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
   logic [7:0]         a_s_data, a_m_data;
   logic [1:0]         a_m_row, a_m_col;
   logic signed [10:0] a_m_xs, a_m_ys;
   logic               a_m_sof, a_m_eof, a_frame_done, a_busy;

   logic                 b_start, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
   logic [7:0]           b_s_data, b_m_data;
   logic [0:0]           b_m_row, b_m_col;
   logic signed [B_CW-1:0] b_m_xs, b_m_ys;
   logic                 b_m_sof, b_m_eof, b_frame_done, b_busy;

   pixel_coord_tagger #(.ROWS(3), .COLS(4), .PIX_W(8), .COORD_W(11)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .s_valid(a_s_valid), .s_ready(a_s_ready),
      .s_data(a_s_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
      .m_row(a_m_row), .m_col(a_m_col), .m_xs(a_m_xs), .m_ys(a_m_ys), .m_sof(a_m_sof),
      .m_eof(a_m_eof), .frame_done(a_frame_done), .busy(a_busy)
   );

   pixel_coord_tagger #(.ROWS(1), .COLS(1), .PIX_W(8), .COORD_W(B_CW)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .s_valid(b_s_valid), .s_ready(b_s_ready),
      .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
      .m_row(b_m_row), .m_col(b_m_col), .m_xs(b_m_xs), .m_ys(b_m_ys), .m_sof(b_m_sof),
      .m_eof(b_m_eof), .frame_done(b_frame_done), .busy(b_busy)
   );

   typedef struct {
      logic [7:0]         d;
      logic [1:0]         r;
      logic [1:0]         c;
      logic signed [10:0] xs;
      logic signed [10:0] ys;
      logic               sof;
      logic               eof;
   } beat_t;

   beat_t got[$];
   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one 3x4 frame on dut_a, collecting output beats and handshake violations.
   task automatic run_frame(input logic [7:0] base, input bit rnd, input bit mid_start);
      int    acc = 0, cyc = 0, occ = 0, viol_ready = 0, viol_stab = 0, fd_bad = 0;
      bit    done = 0, pulsed = 0, first = 1, first_ready = 0, fd_ok = 0, stall = 0;
      logic [35:0] prev = '0, cur;
      beat_t b;
      got.delete();
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      while (!done && cyc < 2000) begin
         a_s_valid = (acc < 12);
         a_s_data  = base + 8'(acc);
         a_m_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
         a_start   = 1'b0;
         if (mid_start && acc == 5 && !pulsed) begin
            a_start = 1'b1;
            pulsed  = 1;
         end
         @(negedge clk);
         if (first) first_ready = a_s_ready;
         first = 0;
         if (occ == 2 && a_s_ready) viol_ready++;
         cur = {a_m_data, a_m_row, a_m_col, a_m_xs, a_m_ys, a_m_sof, a_m_eof};
         if (stall && cur != prev) viol_stab++;
         if (a_frame_done && !(a_m_valid && a_m_ready && a_m_eof)) fd_bad++;
         if (a_m_valid && a_m_ready) begin
            b.d = a_m_data; b.r = a_m_row; b.c = a_m_col; b.xs = a_m_xs; b.ys = a_m_ys;
            b.sof = a_m_sof; b.eof = a_m_eof;
            got.push_back(b);
            occ--;
            if (a_m_eof) begin
               fd_ok = a_frame_done;
               done  = 1;
            end
         end
         if (a_s_valid && a_s_ready) begin
            acc++;
            occ++;
         end
         stall = a_m_valid && !a_m_ready;
         prev  = cur;
         @(posedge clk); #1;
         cyc++;
      end
      a_s_valid = 1'b0;
      a_start   = 1'b0;
      a_m_ready = 1'b1;
      chk("frame_timeout", done, 1);
      chk("s_ready_after_start", first_ready, 1);
      chk("frame_done_on_eof", fd_ok, 1);
      chk("frame_done_spurious", fd_bad, 0);
      chk("s_ready_with_skid_full", viol_ready, 0);
      chk("payload_stable_stall", viol_stab, 0);
      @(negedge clk);
      chk("busy_after_frame", a_busy, 0);
      chk("frame_done_one_cycle", a_frame_done, 0);
   endtask

   task automatic check_frame(input logic [7:0] base);
      int mism = 0;
      chk("beat_count", got.size(), 12);
      for (int k = 0; k < got.size() && k < 12; k++) begin
         if (got[k].d !== base + 8'(k) || got[k].r !== 2'(k / 4) || got[k].c !== 2'(k % 4) ||
             got[k].xs !== 11'(2 * (k % 4) - 3) || got[k].ys !== 11'(2 * (k / 4) - 2) ||
             got[k].sof !== (k == 0) || got[k].eof !== (k == 11))
            mism++;
      end
      chk("sequence_mismatches", mism, 0);
      if (got.size() == 12) begin
         chk("first_row", got[0].r, 0);
         chk("first_col", got[0].c, 0);
         chk("first_xs", got[0].xs, -3);
         chk("first_ys", got[0].ys, -2);
         chk("first_sof", got[0].sof, 1);
         chk("last_row", got[11].r, 2);
         chk("last_col", got[11].c, 3);
         chk("last_xs", got[11].xs, 3);
         chk("last_ys", got[11].ys, 2);
         chk("last_eof", got[11].eof, 1);
      end
   endtask

   initial begin
      int bad = 0;
      int acc = 0;
      rst = 1'b1;
      a_start = 0; a_s_valid = 0; a_s_data = 0; a_m_ready = 0;
      b_start = 0; b_s_valid = 0; b_s_data = 0; b_m_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", a_s_ready, 0);
      chk("rst_m_valid", a_m_valid, 0);
      chk("rst_payload", {a_m_data, a_m_row, a_m_col, a_m_xs, a_m_ys, a_m_sof, a_m_eof}, 0);
      chk("rst_frame_done", a_frame_done, 0);
      chk("rst_busy", a_busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      a_s_valid = 1'b1;
      a_m_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (a_s_ready || a_m_valid || a_busy) bad++;
      end
      chk("idle_ignores_s_valid", bad, 0);
      a_s_valid = 1'b0;

      run_frame(8'h10, 0, 0);
      check_frame(8'h10);
      run_frame(8'h10, 1, 0);
      check_frame(8'h10);
      run_frame(8'h70, 0, 1);
      check_frame(8'h70);

      // Abort a frame after seven accepts with an asynchronous reset.
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      a_m_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && acc < 7; cyc++) begin
         a_s_valid = 1'b1;
         a_s_data  = 8'hC0 + 8'(acc);
         @(negedge clk);
         if (a_s_valid && a_s_ready) acc++;
         if (acc < 7) begin
            @(posedge clk); #1;
         end
      end
      chk("seven_accepts", acc, 7);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("async_rst_m_valid", a_m_valid, 0);
      chk("async_rst_s_ready", a_s_ready, 0);
      chk("async_rst_busy", a_busy, 0);
      chk("async_rst_payload", {a_m_data, a_m_row, a_m_col, a_m_xs, a_m_ys, a_m_sof, a_m_eof}, 0);
      a_s_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      run_frame(8'h20, 0, 0);
      check_frame(8'h20);

      // 1x1 frame on the second instance.
      @(posedge clk); #1;
      b_start = 1'b1; b_s_valid = 1'b1; b_s_data = 8'hA5; b_m_ready = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      @(negedge clk);
      chk("b_s_ready", b_s_ready, 1);
      chk("b_busy", b_busy, 1);
      @(posedge clk); #1 b_s_valid = 1'b0;
      @(negedge clk);
      chk("b_m_valid", b_m_valid, 1);
      chk("b_data", b_m_data, 8'hA5);
      chk("b_sof", b_m_sof, 1);
      chk("b_eof", b_m_eof, 1);
      chk("b_xs", $signed(b_m_xs), 0);
      chk("b_ys", $signed(b_m_ys), 0);
      chk("b_frame_done", b_frame_done, 1);
      chk("b_s_ready_drain", b_s_ready, 0);
      @(negedge clk);
      chk("b_busy_after", b_busy, 0);
      chk("b_frame_done_after", b_frame_done, 0);
      chk("b_m_valid_after", b_m_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
